// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
//
// Loads a program image from a host byte stream into the nrisc instruction
// memory while keeping the core halted. The stream is a length byte N,
// followed by N data bytes, followed by one checksum byte. The checksum is
// the 8-bit sum of the data bytes. If the checksum matches, the memory
// above the image (addresses N..DEPTH-1) is cleared to zero, and then the
// core is released. If the checksum does not match, or N exceeds DEPTH,
// the core stays halted and err is raised. The rest of the memory is not
// cleared in that case.
//
// Parameters
//   DEPTH      number of memory words, 1..256
//
// Ports
//   c          clock; all state updates on the rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse; starts a load from IDLE, DONE or ERR
//   rx_data    incoming byte from the host stream
//   rx_valid   rx_data holds a valid byte
//   rx_ready   loader accepts a byte this cycle (LEN, DATA and CHK only)
//   mem_addr   memory write address
//   mem_wdata  memory write data
//   MemWrite   memory write strobe, one cycle per word
//   halt       holds the core stopped while high
//   busy       a load is in progress
//   done       the last load completed with a good checksum
//   err        the last load failed
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_loader #(
  parameter int DEPTH = 256
) (
  input  logic       c,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       MemWrite,
  output logic       halt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int DATA_W = 8;

  // The depth is held in 9 bits, so that DEPTH = 256 can be compared with
  // the 9-bit counters without the value wrapping to zero.
  localparam logic [8:0] DEPTH_V = 9'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    CLEAR,
    DONE,
    ERR
  } loaderState;

  loaderState        state;
  logic [8:0]        lenN;     // image length N taken from the stream
  logic [8:0]        idx;      // next data index, and then next clear address
  logic [DATA_W-1:0] sum;      // running modulo-256 checksum
  logic              accept;

  // Checksum accumulation: the plain 8-bit sum, wrapping modulo 256.
  function automatic logic [DATA_W-1:0] checksumAdd(
    input logic [DATA_W-1:0] acc,
    input logic [DATA_W-1:0] b
  );
    return acc + b;
  endfunction

  assign accept = rx_valid & rx_ready;

  // Control and datapath in one registered FSM. rx_ready and the status
  // flags are set on the transition into each state, so that they are
  // already valid in the first cycle of that state. The write strobe is
  // issued in the cycle after the byte is accepted.
  always_ff @(posedge c) begin
    if (reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      MemWrite  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      halt      <= 1'b1;
    end else begin
      MemWrite <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            halt     <= 1'b1;
            sum      <= '0;
            idx      <= '0;
          end
        end

        LEN: begin
          if (accept) begin
            lenN <= {1'b0, rx_data};
            if ({1'b0, rx_data} > DEPTH_V) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else if (rx_data == 8'd0) begin
              state <= CHK;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            MemWrite  <= 1'b1;
            mem_addr  <= idx[7:0];
            mem_wdata <= rx_data;
            sum       <= checksumAdd(sum, rx_data);
            idx       <= idx + 9'd1;
            if (idx + 9'd1 == lenN) begin
              state <= CHK;
            end
          end
        end

        CHK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == sum) begin
              if (lenN < DEPTH_V) begin
                // idx already equals N, so it is the first address to clear.
                state <= CLEAR;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                halt  <= 1'b0;
              end
            end else begin
              state <= ERR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end

        CLEAR: begin
          // DONE is entered one cycle after the last clear write is issued.
          // This keeps MemWrite low for every cycle spent in DONE.
          if (idx == DEPTH_V) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            halt  <= 1'b0;
          end else begin
            MemWrite  <= 1'b1;
            mem_addr  <= idx[7:0];
            mem_wdata <= '0;
            idx       <= idx + 9'd1;
          end
        end

        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          halt     <= 1'b1;
        end
      endcase
    end
  end

endmodule
